// File: rtl/vcska_accum_stage.sv
// Frame accumulator around the external 19-bit carry-skip adder; VCSKA_ACCUM_SAT_EN selects saturating accumulate.
// Latency: result valid 2 cycles after the IN_LAST beat is accepted; 1 beat/cycle throughput.
// Backpressure: IN_READY drops once a last beat is staged and stays low until the result is taken.
module vcska_accum_stage #(
  parameter int W     = 19,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [W-1:0]     IN_DATA,
  input  logic             IN_LAST,
  output logic [W-1:0]     ADD_X,
  output logic [W-1:0]     ADD_Y,
  input  logic [W:0]       ADD_S,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [W-1:0]     OUT_SUM,
  output logic             OUT_OVF,
  output logic [CNT_W-1:0] OUT_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       op_q, op_d;
  logic               op_v_q, op_v_d;
  logic               op_last_q, op_last_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_rdy;
  logic               accept;

  always_comb begin
    in_rdy = 1'b0;
    case (state_q)
      S_IDLE:  in_rdy = 1'b1;
      S_ACC:   in_rdy = ~(op_v_q & op_last_q);
      default: in_rdy = 1'b0;
    endcase
  end

  assign IN_READY = in_rdy & ~RST;
  assign accept   = IN_VALID & IN_READY;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    op_v_d    = op_v_q;
    op_last_d = op_last_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = IN_DATA;
          op_v_d    = 1'b1;
          op_last_d = IN_LAST;
          acc_d     = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        if (op_v_q) begin
`ifdef VCSKA_ACCUM_SAT_EN
          // once saturated, the accumulator is pinned for the rest of the frame
          if (ADD_S[W] | ovf_q) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = ADD_S[W-1:0];
          end
`else
          acc_d = ADD_S[W-1:0];
          ovf_d = ovf_q | ADD_S[W];
`endif
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (op_last_q) state_d = S_DONE;
        end
        if (accept) begin
          op_d      = IN_DATA;
          op_v_d    = 1'b1;
          op_last_d = IN_LAST;
        end else begin
          op_v_d    = 1'b0;
          op_last_d = 1'b0;
        end
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      op_v_q    <= 1'b0;
      op_last_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      op_v_q    <= op_v_d;
      op_last_q <= op_last_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  // adder operands come straight from registers; an empty stage adds zero
  assign ADD_X     = acc_q;
  assign ADD_Y     = op_v_q ? op_q : '0;
  assign OUT_VALID = (state_q == S_DONE);
  assign OUT_SUM   = acc_q;
  assign OUT_OVF   = ovf_q;
  assign OUT_CNT   = cnt_q;

endmodule
